mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding mips_decode. Owns the architectural PC,
//  fetches one instruction at a time over a req/ack instruction-memory port,
//  and presents it to decode with a valid/ready handshake.
//  Resolves the next PC from the pcMuxSel, brcond and operands that come back
//  when the instruction retires. Halts on syscall. Non-speculative: one
//  instruction in flight, no branch delay slot.
// PARAMETERS
//  RESET_PC  32'h0040_0000  PC loaded on reset (start of text segment)
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  rst            in   1   synchronous, active-high reset
//  imem_req       out  1   fetch request; held until imem_ack
//  imem_addr      out  32  fetch address (= pc); stable while imem_req=1
//  imem_ack       in   1   1-cycle pulse; imem_rdata valid in the same cycle
//  imem_rdata     in   32  fetched instruction word
//  if_valid       out  1   if_instr/if_pc/if_pc4 valid for decode
//  if_ready       in   1   decode accepts the instruction (transfer = valid&ready)
//  if_instr       out  32  instruction word
//  if_pc          out  32  PC of if_instr
//  if_pc4         out  32  if_pc+4; link value for jLink_en
//  res_valid      in   1   1-cycle pulse: accepted instruction retired, res_* valid
//  res_pcsel      in   2   pcMuxSel: 00 seq, 01 branch, 10 reg jump, 11 jump
//  res_brcond     in   3   brcond from decode (BR_* encodings; 3'b111 = none)
//  res_rs         in   32  rs_data
//  res_rt         in   32  rt_data
//  res_sys        in   1   ctrl_Sys of the retiring instruction
//  halted         out  1   sticky; set by syscall or misaligned target
//  addr_err       out  1   sticky; next PC had bits[1:0] != 0
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_FETCH. All outputs 0 while rst=1, including
//   imem_req, if_valid, halted and addr_err. Reset dominates every other
//   event in the same cycle. imem is reset by the same rst, so no stale acks
//   arrive after reset.
//  FSM: S_FETCH -> S_VALID -> S_EXEC -> S_FETCH; S_HALT is absorbing.
//   S_FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch rdata into if_instr
//    and go to S_VALID. Zero-wait is legal: req and ack in cycle N gives
//    if_valid in N+1.
//   S_VALID: if_valid=1; if_instr/if_pc/if_pc4 held stable. On if_ready go to
//    S_EXEC; if_valid drops the next cycle.
//   S_EXEC: wait for res_valid, then load pc=next_pc and go to S_FETCH
//    (imem_req high the next cycle).
//    If res_sys=1, go to S_HALT and leave pc unchanged.
//    If next_pc[1:0]!=0, set addr_err and go to S_HALT.
//   S_HALT: imem_req=0, if_valid=0, halted=1. Only rst leaves this state.
//  next_pc (combinational, all arithmetic mod 2^32; 0xFFFF_FFFC+4 wraps to 0):
//   seq  00: pc+4
//   br   01: taken ? pc+4+(sext(if_instr[15:0])<<2) : pc+4
//   jr   10: res_rs
//   j    11: {pc4[31:28], if_instr[25:0], 2'b00}
//  Taken, signed compare on rs: BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0;
//   BLTZ rs<0; BGEZ rs>=0; 3'b111 never taken.
//  Ignored inputs: imem_ack outside S_FETCH, if_ready outside S_VALID,
//   res_valid outside S_EXEC. None of these change state.
// STRUCTURE
//  Shared defines: BR_* brcond encodings (existing); new PCSEL_SEQ/BR/JR/J
//   constants and the fetch state enum (S_FETCH/S_VALID/S_EXEC/S_HALT).
//  Sub-module: mips_next_pc (combinational branch evaluation + target mux).
//  Top module holds the FSM, pc and if_* registers.
// TESTING
//  1. Reset, imem acks 2 cycles after req -> imem_addr=0x0040_0000; if_valid
//     appears the cycle after ack; if_pc4=0x0040_0004.
//  2. Zero-wait ack; if_ready held low 5 cycles -> if_valid stays 1 with stable
//     data; no second imem_req.
//  3. BEQ instr 0x1000_FFFF at pc 0x0040_0010, rs=rt=5 -> next fetch addr
//     0x0040_0010; with rs=5, rt=6 -> 0x0040_0014.
//  4. BLTZ rs=0x8000_0000 -> taken; BGEZ rs=0 -> taken; BGTZ rs=0 -> not taken.
//  5. JR with rs=0x0040_0102 -> addr_err=1, halted=1, imem_req stays 0.
//     J at pc 0x0FFF_FFFC, target 0x0000_010 -> next pc 0x1000_0040.
//  6. syscall retires -> halted=1; rst pulsed in S_VALID and in S_HALT ->
//     restart at 0x0040_0000, halted=0.

Source files
------------

// File: rtl/mips_fetch_unit_pkg.sv
// Shared fetch-stage definitions: branch condition codes, PC mux selects,
// fetch FSM states and the branch-taken evaluation used by the next-PC logic.
package mips_fetch_unit_pkg;

  localparam logic [2:0] BR_EQ   = 3'b000;
  localparam logic [2:0] BR_NE   = 3'b001;
  localparam logic [2:0] BR_LEZ  = 3'b010;
  localparam logic [2:0] BR_GTZ  = 3'b011;
  localparam logic [2:0] BR_LTZ  = 3'b100;
  localparam logic [2:0] BR_GEZ  = 3'b101;
  localparam logic [2:0] BR_NONE = 3'b111;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JR  = 2'b10;
  localparam logic [1:0] PCSEL_J   = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  // All comparisons against zero treat rs as two's complement.
  function automatic logic br_taken(input logic [2:0] brcond,
                                    input logic [31:0] rs,
                                    input logic [31:0] rt);
    logic taken;
    taken = 1'b0;
    case (brcond)
      BR_EQ:   taken = (rs == rt);
      BR_NE:   taken = (rs != rt);
      BR_LEZ:  taken = ($signed(rs) <= 0);
      BR_GTZ:  taken = ($signed(rs) > 0);
      BR_LTZ:  taken = ($signed(rs) < 0);
      BR_GEZ:  taken = ($signed(rs) >= 0);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC resolution: branch evaluation plus the four-way target mux.
// Zero latency; no handshake, the caller decides when the result is used.
module mips_next_pc
  import mips_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic [1:0]  pcsel,
  input  logic [2:0]  brcond,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    case (pcsel)
      PCSEL_SEQ: next_pc = pc4;
      PCSEL_BR:  next_pc = br_taken(brcond, rs, rt) ? (pc4 + br_off) : pc4;
      PCSEL_JR:  next_pc = rs;
      PCSEL_J:   next_pc = {pc4[31:28], instr_idx, 2'b00};
      default:   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Non-speculative fetch stage: one instruction in flight, fetch -> decode -> retire -> next PC.
// if_valid holds with stable data until if_ready; a new fetch starts only after retirement.
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        res_valid,
  input  logic [1:0]  res_pcsel,
  input  logic [2:0]  res_brcond,
  input  logic [31:0] res_rs,
  input  logic [31:0] res_rt,
  input  logic        res_sys,
  output logic        halted,
  output logic        addr_err
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic         addr_err_q;
  logic [31:0]  next_pc;
  logic         misaligned;

  mips_next_pc u_next_pc (
    .pc        (pc),
    .instr_idx (instr[25:0]),
    .pcsel     (res_pcsel),
    .brcond    (res_brcond),
    .rs        (res_rs),
    .rt        (res_rt),
    .next_pc   (next_pc)
  );

  assign misaligned = (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem_ack) state_nxt = S_VALID;
      S_VALID: if (if_ready) state_nxt = S_EXEC;
      S_EXEC:  if (res_valid) state_nxt = (res_sys || misaligned) ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // A syscall freezes pc as-is; a bad target also leaves pc at the offending instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr      <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      if (state == S_FETCH && imem_ack)
        instr <= imem_rdata;
      if (state == S_EXEC && res_valid && !res_sys) begin
        if (misaligned) addr_err_q <= 1'b1;
        else            pc         <= next_pc;
      end
    end
  end

  // Every output is forced low while rst is asserted, even though state already reads S_FETCH.
  assign imem_req  = !rst && (state == S_FETCH);
  assign imem_addr = rst ? 32'd0 : pc;
  assign if_valid  = !rst && (state == S_VALID);
  assign if_instr  = rst ? 32'd0 : instr;
  assign if_pc     = rst ? 32'd0 : pc;
  assign if_pc4    = rst ? 32'd0 : (pc + 32'd4);
  assign halted    = !rst && (state == S_HALT);
  assign addr_err  = !rst && addr_err_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: expected fetch addresses and decode
// presentations are queued by the stimulus and checked by an independent monitor.
module tb_mips_fetch_unit;
  import mips_fetch_unit_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } pres_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        res_valid;
  logic [1:0]  res_pcsel;
  logic [2:0]  res_brcond;
  logic [31:0] res_rs;
  logic [31:0] res_rt;
  logic        res_sys;
  logic        halted;
  logic        addr_err;

  int checks = 0;
  int errors = 0;
  int ack_delay = 2;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] addr_q [$];
  pres_t       pres_q [$];

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4),
    .res_valid  (res_valid),
    .res_pcsel  (res_pcsel),
    .res_brcond (res_brcond),
    .res_rs     (res_rs),
    .res_rt     (res_rt),
    .res_sys    (res_sys),
    .halted     (halted),
    .addr_err   (addr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'd0;
  endfunction

  // Expected fetch address plus the decode presentation it should produce.
  task automatic expect_fetch(input logic [31:0] a, input logic [31:0] instr);
    pres_t p;
    p.pc = a; p.instr = instr; p.pc4 = a + 32'd4;
    addr_q.push_back(a);
    pres_q.push_back(p);
  endtask

  // Instruction memory: ack after ack_delay cycles of request, data in the ack cycle.
  initial begin
    int cnt;
    cnt = 0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (cnt >= ack_delay) begin
          imem_ack = 1'b1;
          imem_rdata = mem_rd(imem_addr);
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Monitor: fetch addresses at each ack, decode presentation on each new if_valid.
  initial begin
    logic  prev_valid;
    pres_t cur;
    prev_valid = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (imem_req && imem_ack) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch: got addr %h expected none", imem_addr);
        end else chk("fetch_addr", imem_addr, addr_q.pop_front());
      end
      if (if_valid && !prev_valid) begin
        if (pres_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got pc %h expected none", if_pc);
        end else begin
          cur = pres_q.pop_front();
          chk("if_pc", if_pc, cur.pc);
          chk("if_instr", if_instr, cur.instr);
          chk("if_pc4", if_pc4, cur.pc4);
        end
      end else if (if_valid) begin
        chk("hold_instr", if_instr, cur.instr);
        chk("hold_pc", if_pc, cur.pc);
      end
      prev_valid = if_valid;
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!if_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!if_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout: got if_valid 0 expected 1");
    end
  endtask

  task automatic accept(input int hold);
    wait_valid();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("no_second_req", {31'd0, imem_req}, 32'd0);
      res_valid = (i == 1);
    end
    res_valid = 1'b0;
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    chk("valid_drop", {31'd0, if_valid}, 32'd0);
  endtask

  task automatic retire(input logic [1:0] sel, input logic [2:0] br,
                        input logic [31:0] rs, input logic [31:0] rt, input logic sys);
    @(negedge clk);
    res_pcsel = sel; res_brcond = br; res_rs = rs; res_rt = rt; res_sys = sys;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic step(input logic [31:0] next_a, input logic [1:0] sel, input logic [2:0] br,
                      input logic [31:0] rs, input logic [31:0] rt);
    accept(0);
    expect_fetch(next_a, mem_rd(next_a));
    retire(sel, br, rs, rt, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; if_ready = 1'b0; res_valid = 1'b0; res_pcsel = 2'b00;
    res_brcond = BR_NONE; res_rs = 32'd0; res_rt = 32'd0; res_sys = 1'b0;

    mem[32'h0040_0000] = 32'h0000_0000;
    mem[32'h0040_0004] = 32'h8C01_0000;
    mem[32'h0040_0010] = 32'h1000_FFFF;
    mem[32'h0040_0014] = 32'h0400_0003;
    mem[32'h0040_0024] = 32'h0401_0002;
    mem[32'h0040_0030] = 32'h1C00_0005;
    mem[32'h0040_0034] = 32'h1800_0004;
    mem[32'h0040_0048] = 32'h1422_0002;
    mem[32'h0040_0054] = 32'h0000_0008;
    mem[32'h0FFF_FFFC] = 32'h0800_0010;
    mem[32'h1000_0040] = 32'h0000_0008;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_addr", imem_addr, 32'd0);

    // Test 1: ack two cycles after request, if_valid the cycle after ack.
    expect_fetch(32'h0040_0000, 32'h0000_0000);
    rst = 1'b0;
    n = 0;
    while (!(imem_req && imem_ack) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("valid_before_ack_edge", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("valid_after_ack", {31'd0, if_valid}, 32'd1);
    chk("first_pc4", if_pc4, 32'h0040_0004);
    ack_delay = 0;
    step(32'h0040_0004, PCSEL_SEQ, BR_NONE, 32'd0, 32'd0);

    // Test 2: zero-wait fetch, decode stalls 5 cycles; stray res_valid ignored.
    accept(5);
    expect_fetch(32'h0040_0010, mem_rd(32'h0040_0010));
    retire(PCSEL_JR, BR_NONE, 32'h0040_0010, 32'd0, 1'b0);

    // Test 3: BEQ back to itself when equal, fall through when not.
    step(32'h0040_0010, PCSEL_BR, BR_EQ, 32'd5, 32'd5);
    step(32'h0040_0014, PCSEL_BR, BR_EQ, 32'd5, 32'd6);

    // Test 4: signed compares against zero, plus BNE.
    step(32'h0040_0024, PCSEL_BR, BR_LTZ, 32'h8000_0000, 32'd0);
    step(32'h0040_0030, PCSEL_BR, BR_GEZ, 32'd0, 32'd0);
    step(32'h0040_0034, PCSEL_BR, BR_GTZ, 32'd0, 32'd0);
    step(32'h0040_0048, PCSEL_BR, BR_LEZ, 32'hFFFF_FFFF, 32'd0);
    step(32'h0040_0054, PCSEL_BR, BR_NE, 32'd1, 32'd2);

    // Test 5: J keeps the upper nibble of pc+4, then a misaligned JR halts.
    step(32'h0FFF_FFFC, PCSEL_JR, BR_NONE, 32'h0FFF_FFFC, 32'd0);
    step(32'h1000_0040, PCSEL_J, BR_NONE, 32'd0, 32'd0);
    accept(0);
    retire(PCSEL_JR, BR_NONE, 32'h0040_0102, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("err_addr_err", {31'd0, addr_err}, 32'd1);
      chk("err_halted", {31'd0, halted}, 32'd1);
      chk("err_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end

    // Test 6: reset out of S_HALT, reset during S_VALID, then syscall.
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("halt_rst");
    expect_fetch(32'h0040_0000, 32'h0000_0000);
    rst = 1'b0;
    wait_valid();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("valid_rst");
    expect_fetch(32'h0040_0000, 32'h0000_0000);
    rst = 1'b0;
    accept(0);
    retire(PCSEL_SEQ, BR_NONE, 32'd0, 32'd0, 1'b1);
    chk("sys_halted", {31'd0, halted}, 32'd1);
    chk("sys_addr_err", {31'd0, addr_err}, 32'd0);
    @(negedge clk);
    chk("sys_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    expect_fetch(32'h0040_0000, 32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_halted", {31'd0, halted}, 32'd0);
    accept(0);
    repeat (2) @(negedge clk);
    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("pres_q_empty", pres_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
